i2c_target: RTL and testbench
=============================

# i2c_target

Single-address I2C target (slave) that answers the team's I2C master controller on the same two-wire bus. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address, and ACKs. On a write it assembles 16-bit words (MSB byte first) for the fabric. On a read it serialises a 16-bit word supplied by the fabric. It is used in simulation as the bus-functional far end of the master, and in hardware as a configurable register port.

## Interface
- `DEV_ADDR`, default 7'h3C: 7-bit address this target answers to.
- `clk_in` in 1: system clock, 50 MHz; must be ≥ 16× SCL frequency.
- `reset` in 1: asynchronous, active-low reset.
- `i2c_scl` in 1: bus clock; the target never stretches it.
- `i2c_sda` inout 1: open-drain data line, driven only to 0 or released to z.
- `tx_data` in 16: word returned on a read, sampled when the address byte completes.
- `rx_data` out 16: last complete word received on a write.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high from an address match until STOP or a repeated START.
- `states` out 8: current FSM encoding, for debug only.

## Operation
- Two-flop synchroniser on SCL and SDA, plus one delay register for edge detection. All bus events act on the synchronised versions.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Either one is detected in any state and overrides all other activity.
- FSM states and codes:
  - IDLE 0x00
  - ADDR 0x01
  - ADDR_ACK 0x02
  - RX_BYTE 0x03
  - RX_ACK 0x04
  - TX_BYTE 0x05
  - TX_ACK 0x06
  - IGNORE 0x07
- START from any state goes to ADDR and clears the bit and byte counters. A repeated START discards any partial word.
- STOP from any state goes to IDLE, releases SDA and discards any partial word.
- ADDR: shift SDA in MSB first on each SCL rise, 8 bits (7-bit address, then R/W).
  - Address equals DEV_ADDR: go to ADDR_ACK. If R/W = 1, latch `tx_data` into the shift register.
  - Address mismatch: go to IGNORE. SDA is never driven.
- ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall, then release. Next state is RX_BYTE if R/W = 0, TX_BYTE if R/W = 1.
- RX_BYTE: shift in 8 bits.
  - Byte 0 goes to the high half of the holding register, byte 1 to the low half.
  - On the SCL rise of bit 8 of byte 1, copy the holding register to `rx_data` and pulse `rx_valid`.
  - Then go to RX_ACK. The target always ACKs data bytes.
- RX_ACK: same drive window as ADDR_ACK, then back to RX_BYTE. The byte counter wraps, so 4 bytes produce 2 words and an odd trailing byte is dropped at STOP.
- TX_BYTE: drive bit 7..0 (high byte first) by changing SDA only on SCL falls. A 1 bit means SDA is released.
  - The first bit is driven at the SCL fall that ends the ADDR_ACK window.
  - After 8 bits, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on the 9th SCL rise.
  - ACK (0): continue to the next byte. After byte 1, reload from `tx_data`.
  - NACK (1): go to IGNORE.
- IGNORE: SDA released; wait for START or STOP.

## Timing
- Reset values: SDA released (z), `rx_data` 0x0000, `rx_valid` 0, `busy` 0, `states` 0x00.
- Reset asserted mid-transfer releases SDA immediately (asynchronous) and returns to IDLE.
- Bus-to-internal latency is 3 `clk_in` cycles. SDA output changes 3–4 cycles after the physical SCL fall, which is well inside the tHD;DAT margin at 100 kHz.
- `rx_valid` is high for exactly 1 cycle, 3 cycles after the physical SCL rise of the last data bit.
- `busy` rises in the cycle the address match is decided and falls in the cycle STOP or START is detected.
- A START and a SCL edge detected in the same cycle: the START wins and the edge is ignored.

## Structure
- Package `i2c_pkg`:
  - FSM state codes.
  - ACK = 1'b0, NACK = 1'b1.
  - Bit-count width.
- Sub-module `i2c_line_sync`: 2-FF synchroniser, delay register, and rise/fall outputs. It is instantiated once for SCL and once for SDA.
- The open-drain SDA conversion is a single continuous assignment at the top level.

## Test plan
- Write: master sends dev 0x78 (0x3C, W), data 0xBEEF → target ACKs all 3 bytes, `rx_data` = 0xBEEF, `rx_valid` pulses once, `busy` drops at STOP.
- Address mismatch: dev 0x7A → SDA never driven low, `states` = 0x07 until STOP, no `rx_valid`.
- Read: `tx_data` = 0xA55A, dev 0x79, master ACKs byte 0 and NACKs byte 1 → bus carries 0xA5 then 0x5A, target in IGNORE, SDA released.
- Multi-word write: 0x1234 then 0x5678 in one transaction → two `rx_valid` pulses, with `rx_data` 0x1234 then 0x5678.
- Repeated START after 1 data byte 0x12, then a new write of 0xCAFE → partial word discarded, single `rx_valid` with 0xCAFE.
- `reset` low while the target drives the ACK → SDA released within the same cycle, all outputs at reset values, and the next START is handled normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state codes, ACK/NACK levels
// and the width of the per-byte bit counter.
`timescale 1ns/1ps
package i2c_pkg;

   typedef enum logic [7:0] {
      ST_IDLE     = 8'h00,
      ST_ADDR     = 8'h01,
      ST_ADDR_ACK = 8'h02,
      ST_RX_BYTE  = 8'h03,
      ST_RX_ACK   = 8'h04,
      ST_TX_BYTE  = 8'h05,
      ST_TX_ACK   = 8'h06,
      ST_IGNORE   = 8'h07
   } state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one bus line plus a delay stage that yields
// single-cycle rise/fall strobes in the system clock domain.
`timescale 1ns/1ps
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic ff1, ff2, dly;

   // Reset to the idle (pulled-up) level so no spurious edges appear at release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ff1 <= 1'b1;
         ff2 <= 1'b1;
         dly <= 1'b1;
      end else begin
         ff1 <= din;
         ff2 <= ff1;
         dly <= ff2;
      end
   end

   assign level = ff2;
   assign rise  = ff2 & ~dly;
   assign fall  = ~ff2 & dly;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: writes are assembled into 16-bit words,
// reads serialise a 16-bit word from the fabric, high byte first.
`timescale 1ns/1ps
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h3C
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        i2c_scl,
   inout  wire         i2c_sda,
   input  logic [15:0] tx_data,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic [7:0]  states
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   state_t                 state;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   byte_cnt;
   logic [6:0]             shift;
   logic                   rw;
   logic [7:0]             hold;
   logic [15:0]            tx_word;
   logic                   sda_out;

   i2c_line_sync u_scl_sync (
      .clk   (clk_in),
      .reset (reset),
      .din   (i2c_scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk   (clk_in),
      .reset (reset),
      .din   (i2c_sda),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         byte_cnt <= 1'b0;
         shift    <= '0;
         rw       <= 1'b0;
         hold     <= '0;
         tx_word  <= '0;
         sda_out  <= NACK;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (start_det) begin
            state    <= ST_ADDR;
            bit_cnt  <= '0;
            byte_cnt <= 1'b0;
            busy     <= 1'b0;
            sda_out  <= NACK;
         end else if (stop_det) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= 1'b0;
            busy     <= 1'b0;
            sda_out  <= NACK;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  // Eighth rise carries R/W; shift already holds the 7-bit address.
                  if (bit_cnt == BIT_CNT_W'(7)) begin
                     bit_cnt <= '0;
                     if (shift == DEV_ADDR) begin
                        state <= ST_ADDR_ACK;
                        busy  <= 1'b1;
                        rw    <= sda_lvl;
                        if (sda_lvl) tx_word <= tx_data;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else begin
                     shift   <= {shift[5:0], sda_lvl};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_ADDR_ACK: if (scl_fall) begin
                  // First fall opens the ACK window, second fall closes it.
                  if (sda_out == NACK) begin
                     sda_out <= ACK;
                  end else if (rw) begin
                     state   <= ST_TX_BYTE;
                     sda_out <= tx_word[15];
                     tx_word <= {tx_word[14:0], 1'b0};
                     bit_cnt <= BIT_CNT_W'(1);
                  end else begin
                     state   <= ST_RX_BYTE;
                     sda_out <= NACK;
                  end
               end
               ST_RX_BYTE: if (scl_rise) begin
                  if (bit_cnt == BIT_CNT_W'(7)) begin
                     bit_cnt  <= '0;
                     state    <= ST_RX_ACK;
                     byte_cnt <= ~byte_cnt;
                     if (!byte_cnt) begin
                        hold <= {shift, sda_lvl};
                     end else begin
                        rx_data  <= {hold, shift, sda_lvl};
                        rx_valid <= 1'b1;
                     end
                  end else begin
                     shift   <= {shift[5:0], sda_lvl};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_RX_ACK: if (scl_fall) begin
                  if (sda_out == NACK) begin
                     sda_out <= ACK;
                  end else begin
                     sda_out <= NACK;
                     state   <= ST_RX_BYTE;
                  end
               end
               ST_TX_BYTE: if (scl_fall) begin
                  if (bit_cnt == BIT_CNT_W'(8)) begin
                     sda_out <= NACK;
                     state   <= ST_TX_ACK;
                     bit_cnt <= '0;
                  end else begin
                     sda_out <= tx_word[15];
                     tx_word <= {tx_word[14:0], 1'b0};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_TX_ACK: if (scl_rise) begin
                  if (sda_lvl == ACK) begin
                     state    <= ST_TX_BYTE;
                     byte_cnt <= ~byte_cnt;
                     if (byte_cnt) tx_word <= tx_data;
                  end else begin
                     state <= ST_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign states  = state;
   assign i2c_sda = (sda_out == ACK) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target, with a transaction-level model
// of expected ACKs, words and read bytes.
`timescale 1ns/1ps
module tb_i2c_target;

   localparam logic [6:0] DEV = 7'h3C;
   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m_scl, m_sda;
   logic [15:0] tx_data;
   logic [15:0] rx_data;
   logic        rx_valid, busy;
   logic [7:0]  states;
   wire         sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_sda ? 1'bz : 1'b0;

   always #10 clk = ~clk;

   i2c_target #(.DEV_ADDR(DEV)) dut (
      .clk_in   (clk),
      .reset    (rst_n),
      .i2c_scl  (m_scl),
      .i2c_sda  (sda_bus),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .states   (states)
   );

   int total = 0;
   int bad   = 0;
   int rx_pulses = 0;
   int since_rise = 100;
   logic scl_seen = 1'b1;
   bit quiet = 1'b0;

   logic [15:0] exp_words[$];
   logic [7:0]  wr_bytes[$];
   logic [15:0] rd_words[$];
   logic [7:0]  rd_got[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare: every rx_valid pulse must match the next expected word.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (m_scl && !scl_seen) since_rise = 0;
         else if (since_rise < 1000) since_rise++;
         scl_seen = m_scl;
         if (rx_valid === 1'b1) begin
            rx_pulses++;
            if (exp_words.size() == 0) begin
               check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
            end else begin
               check("rx_data", 32'(rx_data), 32'(exp_words.pop_front()));
               check("rx_valid_latency", 32'(since_rise), 32'd3);
            end
         end
         if (quiet && m_sda) check("sda_not_driven", 32'(sda_bus), 32'd1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required $finish before 2 ms");
      $fatal(1);
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b0; wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic bus_stop();
      m_sda = 1'b0; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b1; wq();
   endtask

   task automatic put_bit(input logic b);
      m_sda = b; wq();
      m_scl = 1'b1; wq();
      wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic get_bit(output logic b);
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      b = sda_bus; wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic put_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
      get_bit(ack);
   endtask

   task automatic get_byte(input logic ack_in, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         v[i] = b;
      end
      put_bit(ack_in);
   endtask

   // Write wr_bytes to addr; matched target forms a word from each byte pair.
   task automatic do_write(input logic [6:0] addr, input bit do_stop);
      bit   hit;
      logic a;
      hit = (addr == DEV);
      bus_start();
      quiet = !hit;
      put_byte({addr, 1'b0}, a);
      check("addr_ack", 32'(a), hit ? 32'd0 : 32'd1);
      check("state_after_addr", 32'(states), hit ? 32'h03 : 32'h07);
      check("busy_after_addr", 32'(busy), hit ? 32'd1 : 32'd0);
      for (int i = 0; i < wr_bytes.size(); i++) begin
         if (hit && (i % 2 == 1)) exp_words.push_back({wr_bytes[i-1], wr_bytes[i]});
         put_byte(wr_bytes[i], a);
         check("data_ack", 32'(a), hit ? 32'd0 : 32'd1);
      end
      if (do_stop) begin
         bus_stop();
         wq();
         check("busy_after_stop", 32'(busy), 32'd0);
         check("state_after_stop", 32'(states), 32'h00);
      end
      quiet = 1'b0;
      check("words_delivered", 32'(exp_words.size()), 32'd0);
   endtask

   // Read nbytes from DEV; tx_data advances to the next word after each reload.
   task automatic do_read(input int nbytes);
      logic       a;
      logic [7:0] v;
      logic [7:0] e;
      rd_got.delete();
      tx_data = rd_words[0];
      bus_start();
      put_byte({DEV, 1'b1}, a);
      check("rd_addr_ack", 32'(a), 32'd0);
      check("rd_state_after_addr", 32'(states), 32'h05);
      check("rd_busy", 32'(busy), 32'd1);
      if (rd_words.size() > 1) tx_data = rd_words[1];
      for (int i = 0; i < nbytes; i++) begin
         get_byte(i == nbytes - 1, v);
         e = (i % 2 == 0) ? rd_words[i/2][15:8] : rd_words[i/2][7:0];
         check("rd_byte", 32'(v), 32'(e));
         rd_got.push_back(v);
         if ((i % 2 == 1) && (i/2 + 2 < rd_words.size())) tx_data = rd_words[i/2 + 2];
      end
      check("rd_state_after_nack", 32'(states), 32'h07);
      check("rd_sda_released", 32'(sda_bus), 32'd1);
      check("rd_busy_after_nack", 32'(busy), 32'd1);
      bus_stop();
      wq();
      check("rd_busy_after_stop", 32'(busy), 32'd0);
      check("rd_state_after_stop", 32'(states), 32'h00);
   endtask

   initial begin
      int p0;
      int kind, nb, nw;
      logic [6:0] addr;
      logic [7:0] dev_w;

      rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; tx_data = '0;
      repeat (3) @(negedge clk);
      check("reset_sda", 32'(sda_bus), 32'd1);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_states", 32'(states), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single word write
      p0 = rx_pulses;
      wr_bytes = '{8'hBE, 8'hEF};
      do_write(DEV, 1'b1);
      check("beef_rx_data", 32'(rx_data), 32'h0000BEEF);
      check("beef_pulses", 32'(rx_pulses - p0), 32'd1);

      // Address mismatch (0x7A on the wire)
      p0 = rx_pulses;
      wr_bytes = '{8'h11, 8'h22};
      do_write(7'h3D, 1'b1);
      check("mismatch_pulses", 32'(rx_pulses - p0), 32'd0);

      // Read with ACK then NACK
      rd_words = '{16'hA55A};
      do_read(2);
      check("read_byte0_literal", 32'(rd_got[0]), 32'h000000A5);
      check("read_byte1_literal", 32'(rd_got[1]), 32'h0000005A);

      // Two words in one transaction
      p0 = rx_pulses;
      wr_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
      do_write(DEV, 1'b1);
      check("multi_rx_data", 32'(rx_data), 32'h00005678);
      check("multi_pulses", 32'(rx_pulses - p0), 32'd2);

      // Repeated START after a partial word
      p0 = rx_pulses;
      wr_bytes = '{8'h12};
      do_write(DEV, 1'b0);
      wr_bytes = '{8'hCA, 8'hFE};
      do_write(DEV, 1'b1);
      check("rstart_rx_data", 32'(rx_data), 32'h0000CAFE);
      check("rstart_pulses", 32'(rx_pulses - p0), 32'd1);

      // Reset while the target drives the address ACK
      bus_start();
      dev_w = {DEV, 1'b0};
      for (int i = 7; i >= 0; i--) put_bit(dev_w[i]);
      m_sda = 1'b1;
      @(negedge clk);
      check("ack_driven_before_reset", 32'(sda_bus), 32'd0);
      rst_n = 1'b0;
      #1;
      check("async_reset_sda", 32'(sda_bus), 32'd1);
      check("async_reset_rx_data", 32'(rx_data), 32'd0);
      check("async_reset_rx_valid", 32'(rx_valid), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      check("async_reset_states", 32'(states), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      bus_stop();
      wr_bytes = '{8'hCA, 8'hFE};
      do_write(DEV, 1'b1);
      check("post_reset_rx_data", 32'(rx_data), 32'h0000CAFE);

      // Randomised transactions
      for (int it = 0; it < 10; it++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            nb = $urandom_range(1, 5);
            wr_bytes.delete();
            for (int j = 0; j < nb; j++) wr_bytes.push_back(8'($urandom_range(0, 255)));
            do_write(DEV, 1'b1);
         end else if (kind == 1) begin
            addr = 7'($urandom_range(0, 127));
            if (addr == DEV) addr = addr ^ 7'h01;
            nb = $urandom_range(1, 3);
            wr_bytes.delete();
            for (int j = 0; j < nb; j++) wr_bytes.push_back(8'($urandom_range(0, 255)));
            do_write(addr, 1'b1);
         end else begin
            nw = $urandom_range(1, 3);
            rd_words.delete();
            for (int j = 0; j < nw; j++) rd_words.push_back(16'($urandom_range(0, 65535)));
            do_read($urandom_range(1, 2 * nw));
         end
      end

      repeat (10) @(negedge clk);
      check("no_leftover_words", 32'(exp_words.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
